// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, defaults and helpers for the Sobel scan controller
package sobel_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sobel_state_t;

  localparam int SOBEL_IMG_W_DEF = 512;
  localparam int SOBEL_IMG_H_DEF = 512;

  // Smallest address width that covers every pixel of a w x h image
  function automatic int sobel_addr_w(input int w, input int h);
    return ((w * h) <= 2) ? 1 : $clog2(w * h);
  endfunction

endpackage

// File: rtl/sobel_delay_line.sv
// rtl/sobel_delay_line.sv - PIPE-stage {we, addr} delay with synchronous clear
module sobel_delay_line #(
  parameter int PIPE = 2,
  parameter int AW   = 18
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  output logic          o_we,
  output logic [AW-1:0] o_addr
);

  generate
    if (PIPE == 0) begin : g_pass
      assign o_we   = i_we;
      assign o_addr = i_addr;
    end else begin : g_pipe
      logic [PIPE-1:0] r_we;
      logic [AW-1:0]   r_addr [PIPE];

      // Shift the write strobe and its address down the pipe; clear drops anything in flight
      always_ff @(posedge i_clk) begin
        if (i_clr) begin
          r_we <= '0;
          for (int i = 0; i < PIPE; i++) begin
            r_addr[i] <= '0;
          end
        end else begin
          r_we[0]   <= i_we;
          r_addr[0] <= i_addr;
          for (int i = 1; i < PIPE; i++) begin
            r_we[i]   <= r_we[i-1];
            r_addr[i] <= r_addr[i-1];
          end
        end
      end

      assign o_we   = r_we[PIPE-1];
      assign o_addr = r_addr[PIPE-1];
    end
  endgenerate

endmodule

// File: rtl/sobel_scan_ctrl.sv
// rtl/sobel_scan_ctrl.sv - raster-scan sequencer for the Sobel datapath (optional SOBEL_BORDER_CLEAR_EN)
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W  = SOBEL_IMG_W_DEF,
  parameter int IMG_H  = SOBEL_IMG_H_DEF,
  parameter int ADDR_W = sobel_addr_w(SOBEL_IMG_W_DEF, SOBEL_IMG_H_DEF),
  parameter int PIPE   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_addr,
  output logic              shift_en,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr
`ifdef SOBEL_BORDER_CLEAR_EN
  ,
  output logic              border_we,
  output logic [ADDR_W-1:0] border_addr
`endif
);

  localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DRAIN_W = $clog2(PIPE + 2);

  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0]  ADDR_OFS = ADDR_W'(IMG_W + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(PIPE);

  sobel_state_t       r_state;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [ADDR_W-1:0]  r_addr;
  logic [DRAIN_W-1:0] r_drain;
  logic               r_busy;
  logic               r_done;

  logic               r_shift_en;
  logic               r_int_we;
  logic [ADDR_W-1:0]  r_int_addr;

  logic               w_rd;
  logic               w_last_px;
  logic               w_interior;

  assign w_rd       = (r_state == ST_RUN) && !stall;
  assign w_last_px  = (r_row == ROW_LAST) && (r_col == COL_LAST);
  // Pixel at (r,c) completes the 3x3 window centred on (r-1,c-1)
  assign w_interior = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  // Frame sequencer: state, raster counters, drain timer and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_row   <= '0;
            r_col   <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            if (w_last_px) begin
              r_state <= ST_DRAIN;
              r_drain <= '0;
              r_row   <= '0;
              r_col   <= '0;
              r_addr  <= '0;
            end else begin
              // Linear address advances alongside (r,c), so no multiply is needed
              r_addr <= r_addr + 1'b1;
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          // Covers the read latency plus the datapath pipe so the last result lands
          if (r_drain == DRAIN_END) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Track the read one cycle later, when its data reaches the datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift_en <= 1'b0;
      r_int_we   <= 1'b0;
      r_int_addr <= '0;
    end else begin
      r_shift_en <= w_rd;
      r_int_we   <= w_rd && w_interior;
      r_int_addr <= (w_rd && w_interior) ? (r_addr - ADDR_OFS) : '0;
    end
  end

  sobel_delay_line #(
    .PIPE (PIPE),
    .AW   (ADDR_W)
  ) u_delay (
    .i_clk  (clk),
    .i_clr  (reset),
    .i_we   (r_int_we),
    .i_addr (r_int_addr),
    .o_we   (out_we),
    .o_addr (out_addr)
  );

`ifdef SOBEL_BORDER_CLEAR_EN
  logic              r_border_we;
  logic [ADDR_W-1:0] r_border_addr;
  logic              w_on_border;

  assign w_on_border = (r_row == '0) || (r_row == ROW_LAST) ||
                       (r_col == '0) || (r_col == COL_LAST);

  // Border clears fire alongside the shift strobe of the edge pixel itself
  always_ff @(posedge clk) begin
    if (reset) begin
      r_border_we   <= 1'b0;
      r_border_addr <= '0;
    end else begin
      r_border_we   <= w_rd && w_on_border;
      r_border_addr <= (w_rd && w_on_border) ? r_addr : '0;
    end
  end

  assign border_we   = r_border_we;
  assign border_addr = r_border_addr;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign in_rd_en = w_rd;
  assign in_addr  = r_addr;
  assign shift_en = r_shift_en;

endmodule
